// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/stall sequencer.
package hazard_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } hz_state_t;

  // A load in EX whose destination is a source of the instruction in ID.
  // Register zero is hard-wired, so it never creates a dependency.
  function automatic logic load_use_hit(input logic             mem_read,
                                        input logic [REG_W-1:0] ld_rt,
                                        input logic [REG_W-1:0] id_rs,
                                        input logic [REG_W-1:0] id_rt);
    return mem_read && (ld_rt != REG_ZERO) && ((ld_rt == id_rs) || (ld_rt == id_rt));
  endfunction

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module hz_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Count qualifying cycles; reset clears.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i) begin
      cnt_o <= sat_inc(cnt_o);
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: load-use stalls, taken-branch flushes and data-memory
// wait freezes, with a sticky timeout error and saturating perf counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [REG_W-1:0] ID_EX_rt_i,
  input  logic [REG_W-1:0] IF_ID_rs_i,
  input  logic [REG_W-1:0] IF_ID_rt_i,
  input  logic             Branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PCWrite_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Bubble_o,
  output logic             EX_M_Hold_o,
  output logic             M_WB_Bubble_o,
  output logic             error_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // One extra bit so the counter can step past MEM_TIMEOUT-1 without wrapping.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              error_q, error_d;

  logic load_use;
  logic mem_stall;
  logic freeze;
  logic lu_bubble;
  logic flush;

  assign load_use  = load_use_hit(ID_EX_MemRead_i, ID_EX_rt_i, IF_ID_rs_i, IF_ID_rt_i);
  assign mem_stall = mem_req_i && !mem_ack_i;

  // Next-state and hazard decisions; a branch is only flushed when nothing
  // else stalls the front end, so it stays in ID until the stall clears.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    error_d    = error_q;
    freeze     = 1'b0;
    lu_bubble  = 1'b0;
    flush      = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          freeze     = 1'b1;
          wait_cnt_d = WAIT_ONE;
          state_d    = MEM_WAIT;
        end else if (load_use) begin
          lu_bubble = 1'b1;
          state_d   = LU_STALL;
        end else if (Branch_taken_i) begin
          flush = 1'b1;
        end
      end
      LU_STALL: begin
        // The bubble already separated the load from its consumer.
        state_d = RUN;
        if (mem_stall) begin
          freeze     = 1'b1;
          wait_cnt_d = WAIT_ONE;
          state_d    = MEM_WAIT;
        end else if (Branch_taken_i) begin
          flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ack_i) begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end else begin
          // Ack cycle: the pipeline advances, so ID hazards apply again.
          wait_cnt_d = '0;
          state_d    = RUN;
          if (load_use) begin
            lu_bubble = 1'b1;
            state_d   = LU_STALL;
          end else if (Branch_taken_i) begin
            flush = 1'b1;
          end
        end
      end
      ERROR: begin
        freeze  = 1'b1;
        error_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign PCWrite_o      = !(freeze || lu_bubble);
  assign IF_ID_Write_o  = !(freeze || lu_bubble);
  assign ID_EX_Bubble_o = lu_bubble;
  assign EX_M_Hold_o    = freeze;
  assign M_WB_Bubble_o  = freeze;
  assign IF_ID_Flush_o  = flush;
  assign error_o        = error_q;

  // Sequencer state register; reset overrides every pending event.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      error_q    <= error_d;
    end
  end

  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (!PCWrite_o),
    .cnt_o (stall_cnt_o)
  );

  hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (IF_ID_Flush_o),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: two sequencers (wide and 2-bit counters) share stimulus,
// a behavioural model queues expected outputs, a monitor compares them.
module tb_hazard_stall_ctrl;

  localparam int MT   = 4;
  localparam int WW   = 16;
  localparam int NW   = 2;
  localparam int WMAX = (1 << WW) - 1;
  localparam int NMAX = (1 << NW) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_read = 1'b0;
  logic [4:0] ex_rt = '0, id_rs = '0, id_rt = '0;
  logic       br = 1'b0, req = 1'b0, ack = 1'b0;

  logic          pcw_w, ifw_w, fl_w, bub_w, hold_w, mwb_w, err_w;
  logic [WW-1:0] scnt_w, fcnt_w;
  logic          pcw_n, ifw_n, fl_n, bub_n, hold_n, mwb_n, err_n;
  logic [NW-1:0] scnt_n, fcnt_n;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(WW)) dut_w (
    .clk_i(clk), .rst_i(rst), .ID_EX_MemRead_i(mem_read), .ID_EX_rt_i(ex_rt),
    .IF_ID_rs_i(id_rs), .IF_ID_rt_i(id_rt), .Branch_taken_i(br),
    .mem_req_i(req), .mem_ack_i(ack), .PCWrite_o(pcw_w), .IF_ID_Write_o(ifw_w),
    .IF_ID_Flush_o(fl_w), .ID_EX_Bubble_o(bub_w), .EX_M_Hold_o(hold_w),
    .M_WB_Bubble_o(mwb_w), .error_o(err_w), .stall_cnt_o(scnt_w), .flush_cnt_o(fcnt_w));

  hazard_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(NW)) dut_n (
    .clk_i(clk), .rst_i(rst), .ID_EX_MemRead_i(mem_read), .ID_EX_rt_i(ex_rt),
    .IF_ID_rs_i(id_rs), .IF_ID_rt_i(id_rt), .Branch_taken_i(br),
    .mem_req_i(req), .mem_ack_i(ack), .PCWrite_o(pcw_n), .IF_ID_Write_o(ifw_n),
    .IF_ID_Flush_o(fl_n), .ID_EX_Bubble_o(bub_n), .EX_M_Hold_o(hold_n),
    .M_WB_Bubble_o(mwb_n), .error_o(err_n), .stall_cnt_o(scnt_n), .flush_cnt_o(fcnt_n));

  typedef struct {
    int  cyc;
    bit  freeze;
    bit  bubble;
    bit  flush;
    bit  err;
    int  stall_w, flush_w, stall_n, flush_n;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model state: what the pipeline is doing, in plain terms.
  bit m_err;        // a memory access timed out
  bit m_waiting;    // a memory access is outstanding
  int m_frozen;     // freeze cycles spent on the outstanding access
  bit m_bubbled;    // last cycle inserted a load-use bubble
  int m_sw, m_fw, m_sn, m_fn;

  task automatic model_reset();
    m_err = 0; m_waiting = 0; m_frozen = 0; m_bubbled = 0;
    m_sw = 0; m_fw = 0; m_sn = 0; m_fn = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp, input int c);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  // Apply one cycle of inputs and queue the expected response.
  task automatic drive(input bit r, input bit mr, input int ert, input int ers,
                       input int ert2, input bit b, input bit rq, input bit ak);
    exp_t e;
    bit lu, fz, bb, fl;
    @(posedge clk); #1;
    cyc++;
    rst = r; mem_read = mr; ex_rt = 5'(ert); id_rs = 5'(ers); id_rt = 5'(ert2);
    br = b; req = rq; ack = ak;
    if (r) begin
      model_reset();
      return;
    end
    lu = mr && (ert != 0) && (ert == ers || ert == ert2);
    fz = 0; bb = 0; fl = 0;
    e.cyc = cyc; e.err = m_err;
    e.stall_w = m_sw; e.flush_w = m_fw; e.stall_n = m_sn; e.flush_n = m_fn;
    if (m_err) begin
      fz = 1;
    end else if (m_waiting && !ak) begin
      fz = 1;
      m_frozen++;
      if (m_frozen == MT) m_err = 1;
    end else if (!m_waiting && rq && !ak) begin
      fz = 1;
      m_waiting = 1;
      m_frozen = 1;
    end else begin
      // Pipeline free to advance: the memory access (if any) completes.
      m_waiting = 0;
      m_frozen = 0;
      if (lu && !m_bubbled) bb = 1;
      else if (b) fl = 1;
    end
    m_bubbled = bb;
    e.freeze = fz; e.bubble = bb; e.flush = fl;
    q.push_back(e);
    if (fz || bb) begin
      if (m_sw < WMAX) m_sw++;
      if (m_sn < NMAX) m_sn++;
    end
    if (fl) begin
      if (m_fw < WMAX) m_fw++;
      if (m_fn < NMAX) m_fn++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare both DUTs against each queued expectation mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pcwrite",   int'(pcw_w),  int'(!(e.freeze || e.bubble)), e.cyc);
        chk("ifid_wr",   int'(ifw_w),  int'(!(e.freeze || e.bubble)), e.cyc);
        chk("ifid_fl",   int'(fl_w),   int'(e.flush),  e.cyc);
        chk("idex_bub",  int'(bub_w),  int'(e.bubble), e.cyc);
        chk("exm_hold",  int'(hold_w), int'(e.freeze), e.cyc);
        chk("mwb_bub",   int'(mwb_w),  int'(e.freeze), e.cyc);
        chk("error",     int'(err_w),  int'(e.err),    e.cyc);
        chk("stall_cnt", int'(scnt_w), e.stall_w, e.cyc);
        chk("flush_cnt", int'(fcnt_w), e.flush_w, e.cyc);
        chk("n_pcwrite", int'(pcw_n),  int'(!(e.freeze || e.bubble)), e.cyc);
        chk("n_flush",   int'(fl_n),   int'(e.flush),  e.cyc);
        chk("n_error",   int'(err_n),  int'(e.err),    e.cyc);
        chk("n_stall_cnt", int'(scnt_n), e.stall_n, e.cyc);
        chk("n_flush_cnt", int'(fcnt_n), e.flush_n, e.cyc);
      end
    end
  end

  // Stimulus: directed scenarios, then biased random traffic.
  initial begin
    int ack_pct;
    model_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Load-use on rs.
    drive(0, 1, 5, 5, 0, 0, 0, 0);
    drive(0, 1, 5, 5, 0, 0, 0, 0);
    idle(2);
    // Load to r0 never stalls.
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Memory wait released by ack on the fourth cycle.
    repeat (3) drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);
    // Load-use together with a taken branch.
    drive(0, 1, 7, 3, 7, 1, 0, 0);
    drive(0, 1, 7, 3, 7, 1, 0, 0);
    idle(2);
    // Memory timeout, error held, then reset recovery.
    repeat (7) drive(0, 0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Saturation of the narrow counter.
    repeat (5) begin
      drive(0, 1, 2, 1, 2, 0, 0, 0);
      idle(1);
    end
    // Reset in the middle of a memory wait.
    repeat (2) drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    ack_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) begin
        case ($urandom_range(0, 2))
          0: ack_pct = 5;
          1: ack_pct = 50;
          default: ack_pct = 90;
        endcase
      end
      drive(($urandom_range(0, 99) < 1),
            ($urandom_range(0, 99) < 35),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 99) < 25),
            ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < ack_pct));
    end
    idle(2);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
